// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_t    : operation encoding presented on opE by the decoder.
//   mdu_state_t : sequencer states of mdu_iter.
//   cnt_width() : width of the iteration counter for a given operand width.
// -----------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } mdu_op_t;

   // State literals carry an ST_ prefix so they cannot collide with the
   // operation literal DIV in the shared package scope.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_t;

   // One bit more than needed to index WIDTH iterations, so the counter can
   // also hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mdu_signfix.sv
// -----------------------------------------------------------------------------
// mdu_signfix
// Combinational conditional two's-complement negate.
//   value  : magnitude to be sign-corrected.
//   negate : 1 -> result = -value, 0 -> result = value.
//   result : sign-corrected value, same width as value.
// -----------------------------------------------------------------------------
module mdu_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   assign result = negate ? (W'(0) - value) : value;

endmodule

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative multiply/divide unit with architectural HI/LO registers for the
// Execute stage. MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (WIDTH shift steps
// plus one sign-fix/write-back cycle); MTHI/MTLO write in one cycle when idle.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset.
//   startE, opE     : launch opE this cycle (ignored while busy).
//   srcaE, srcbE    : multiplicand/dividend and multiplier/divisor.
//   mthiE, mtloE    : write srcaE into HI / LO (ignored while busy).
//   mfE             : an MFHI/MFLO is in Execute this cycle.
//   hi, lo          : architectural HI/LO.
//   busy            : iteration in progress.
//   done            : one-cycle pulse, hi/lo were updated by the last edge.
//   stall_req       : hold Execute while an HI/LO user would see stale data.
// -----------------------------------------------------------------------------
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  mdu_op_t          opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             mthiE,
   input  logic             mtloE,
   input  logic             mfE,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall_req
);

   localparam int CW = cnt_width(WIDTH);

   mdu_state_t         state, state_d;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
   logic               neg_q;    // negate product / quotient
   logic               neg_r;    // negate remainder
   logic               is_mul;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   // ---------------------------------------------------------------- decode
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      // Result is unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable.
      return (sgn && x[WIDTH-1]) ? (WIDTH'(0) - x) : x;
   endfunction

   logic             op_signed, op_div, div0, sa, sb;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign op_signed = (opE == MULT) || (opE == DIV);
   assign op_div    = (opE == DIV)  || (opE == DIVU);
   assign div0      = op_div && (srcbE == '0);
   assign sa        = op_signed & srcaE[WIDTH-1];
   assign sb        = op_signed & srcbE[WIDTH-1];
   assign a_mag     = mag(srcaE, op_signed);
   assign b_mag     = mag(srcbE, op_signed);

   // ------------------------------------------------------- multiply step
   // Add the multiplicand into the upper half when the current multiplier
   // bit (acc[0]) is set, then shift the whole accumulator right by one.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // -------------------------------------------------------- divide step
   // Shift the next dividend bit into the remainder and subtract the divisor
   // if it fits. The subtraction only needs WIDTH bits: when it is kept the
   // true difference is below the divisor. A zero divisor always "fits", so
   // after WIDTH steps the remainder holds the raw dividend and the quotient
   // is all ones, which is exactly the divide-by-zero result.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_sub;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_ok    = div_shift >= {1'b0, opnd};
   assign div_sub   = div_shift[WIDTH-1:0] - opnd;
   assign div_next  = {(div_ok ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};

   // ------------------------------------------------------------ sign fix
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   mdu_signfix #(.W(2*WIDTH)) u_fix_prod (
      .value  (acc),
      .negate (neg_q),
      .result (prod_fix)
   );

   mdu_signfix #(.W(WIDTH)) u_fix_quot (
      .value  (acc[WIDTH-1:0]),
      .negate (neg_q),
      .result (quot_fix)
   );

   mdu_signfix #(.W(WIDTH)) u_fix_rem (
      .value  (acc[2*WIDTH-1:WIDTH]),
      .negate (neg_r),
      .result (rem_fix)
   );

   // ---------------------------------------------------------------- FSM
   logic last;
   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      // NOTE: assign the default before the case so every path drives
      // state_d; a missing assignment would otherwise infer a latch.
      state_d = state;
      case (state)
         ST_IDLE: if (startE) state_d = op_div ? ST_DIV : ST_MUL;
         ST_MUL:  if (last)   state_d = ST_FIX;
         ST_DIV:  if (last)   state_d = ST_FIX;
         ST_FIX:              state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset as well, so an aborted operation
      // leaves no residue visible to a later one.
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_mul <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register in this block
         // updates from pre-edge values regardless of statement order.
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (startE) begin
                  // Start wins over a simultaneous move.
                  cnt    <= '0;
                  is_mul <= ~op_div;
                  if (op_div) begin
                     acc   <= {{WIDTH{1'b0}}, (div0 ? srcaE : a_mag)};
                     opnd  <= b_mag;
                     neg_q <= ~div0 & (sa ^ sb);
                     neg_r <= ~div0 & sa;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, b_mag};
                     opnd  <= a_mag;
                     neg_q <= sa ^ sb;
                     neg_r <= 1'b0;
                  end
               end else begin
                  if (mthiE) hi_q <= srcaE;
                  if (mtloE) lo_q <= srcaE;
               end
            end
            ST_MUL: begin
               acc <= mul_next;
               cnt <= cnt + CW'(1);
            end
            ST_DIV: begin
               acc <= div_next;
               cnt <= cnt + CW'(1);
            end
            ST_FIX: begin
               if (is_mul) begin
                  {hi_q, lo_q} <= prod_fix;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign done      = done_q;
   assign busy      = (state != ST_IDLE);
   assign stall_req = busy & (startE | mthiE | mtloE | mfE);

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Scoreboard bench for mdu_iter (WIDTH=32). Each launched operation pushes its
// expected {hi,lo} and completion cycle; a negedge monitor checks busy, done,
// stall_req every cycle and pops/compares hi/lo on completion. Expected results
// come from plain 64-bit integer arithmetic or literal values.
// -----------------------------------------------------------------------------
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           done_cyc;
   } exp_t;

   logic         clk    = 1'b0;
   logic         reset  = 1'b1;
   logic         startE = 1'b0;
   logic         mthiE  = 1'b0;
   logic         mtloE  = 1'b0;
   logic         mfE    = 1'b0;
   mdu_op_t      opE    = MULT;
   logic [W-1:0] srcaE  = '0;
   logic [W-1:0] srcbE  = '0;
   logic [W-1:0] hi, lo;
   logic         busy, done, stall_req;

   exp_t         sb_q[$];
   int           cyc      = 0;
   int           n_checks = 0;
   int           n_fail   = 0;
   bit           mon_en   = 1'b0;
   logic [W-1:0] arch_hi  = '0;
   logic [W-1:0] arch_lo  = '0;

   mdu_iter #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .startE    (startE),
      .opE       (opE),
      .srcaE     (srcaE),
      .srcbE     (srcbE),
      .mthiE     (mthiE),
      .mtloE     (mtloE),
      .mfE       (mfE),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp_v);
      end
   endtask

   // Reference: architectural MIPS semantics on 64-bit integers.
   function automatic logic [2*W-1:0] ref_model(input mdu_op_t op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      longint          sa, sbv;
      longint unsigned ua, ub;
      logic [W-1:0]    q, r;
      logic [2*W-1:0]  res;
      sa  = $signed(a);
      sbv = $signed(b);
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      case (op)
         MULT:    res = sa * sbv;
         MULTU:   res = ua * ub;
         default: begin
            if (b == '0) begin
               res = {a, {W{1'b1}}};
            end else begin
               if (op == DIV) begin q = sa / sbv; r = sa % sbv; end
               else           begin q = ua / ub;  r = ua % ub;  end
               res = {r, q};
            end
         end
      endcase
      return res;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'd1;
         5:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] e);
      exp_t ent;
      startE = 1'b1; opE = op; srcaE = a; srcbE = b;
      tick();
      startE = 1'b0;
      // Operands are sampled only at the start edge; scramble them now.
      srcaE = 32'($urandom);
      srcbE = 32'($urandom);
      ent.hi       = e[2*W-1:W];
      ent.lo       = e[W-1:0];
      ent.done_cyc = cyc + W + 1;
      sb_q.push_back(ent);
      arch_hi = ent.hi;
      arch_lo = ent.lo;
   endtask

   task automatic wait_done();
      for (int i = 0; i < W + 10; i++) begin
         tick();
         if (done) break;
      end
      check("done_seen", {63'b0, done}, 64'd1);
   endtask

   task automatic run_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] e);
      start_op(op, a, b, e);
      wait_done();
   endtask

   // Monitor: per-cycle control checks and result scoreboard.
   always @(negedge clk) begin : monitor
      bit   eb, ed;
      exp_t e;
      if (mon_en) begin
         eb = (sb_q.size() != 0) && (cyc < sb_q[0].done_cyc);
         ed = (sb_q.size() != 0) && (cyc == sb_q[0].done_cyc);
         check("busy", {63'b0, busy}, {63'b0, eb});
         check("done", {63'b0, done}, {63'b0, ed});
         check("stall_req", {63'b0, stall_req}, {63'b0, eb & (startE | mthiE | mtloE | mfE)});
         check("start_with_move", {63'b0, startE & ~busy & (mthiE | mtloE)}, 64'd0);
         if ((sb_q.size() != 0) && (cyc >= sb_q[0].done_cyc)) begin
            e = sb_q.pop_front();
            check("hi", {32'b0, hi}, {32'b0, e.hi});
            check("lo", {32'b0, lo}, {32'b0, e.lo});
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      mdu_op_t op;
      logic [W-1:0] a, b;

      // ---- reset state (mfE high: stall_req must stay low in IDLE)
      repeat (3) tick();
      reset = 1'b0;
      mfE   = 1'b1;
      #1;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_stall", {63'b0, stall_req}, 64'd0);
      check("rst_hi", {32'b0, hi}, 64'd0);
      check("rst_lo", {32'b0, lo}, 64'd0);
      mfE    = 1'b0;
      mon_en = 1'b1;
      tick();

      // ---- directed vectors, issued back-to-back
      run_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(DIVU,  32'd100,       32'd0,         {32'd100, 32'hFFFF_FFFF});
      run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run_op(DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);
      run_op(DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run_op(MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      tick();

      // ---- moves in IDLE
      srcaE = 32'h0000_1234; mtloE = 1'b1;
      tick();
      mtloE = 1'b0;
      check("mtlo_lo", {32'b0, lo}, 64'h1234);
      check("mtlo_hi", {32'b0, hi}, {32'b0, arch_hi});
      srcaE = 32'hCAFE_F00D; mthiE = 1'b1; mtloE = 1'b1;
      tick();
      mthiE = 1'b0; mtloE = 1'b0;
      check("mthilo_hi", {32'b0, hi}, 64'hCAFE_F00D);
      check("mthilo_lo", {32'b0, lo}, 64'hCAFE_F00D);

      // ---- hazards: MF, moves and a second start while busy
      start_op(MULTU, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000);
      repeat (4) tick();
      mfE = 1'b1;
      srcaE = 32'hDEAD_BEEF; mthiE = 1'b1; mtloE = 1'b1;
      tick();
      startE = 1'b1; opE = DIV; srcbE = 32'd5;
      repeat (2) tick();
      startE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
      wait_done();
      check("mf_read_hi", {32'b0, hi}, 64'h3);
      check("mf_read_lo", {32'b0, lo}, 64'h0);
      tick();
      mfE = 1'b0;
      check("busy_move_ignored", {32'b0, hi}, 64'h3);

      // ---- reset in the middle of a divide
      start_op(DIV, 32'd1000, 32'd7, 64'h0000_0006_0000_008E);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      sb_q.delete();
      reset = 1'b0;
      arch_hi = '0;
      arch_lo = '0;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_hi", {32'b0, hi}, 64'd0);
      check("abort_lo", {32'b0, lo}, 64'd0);
      repeat (W + 5) tick();
      run_op(MULT, 32'd3, 32'd4, 64'd12);

      // ---- randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         op = mdu_op_t'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         run_op(op, a, b, ref_model(op, a, b));
         if ($urandom_range(0, 2) == 0) tick();
      end

      repeat (3) tick();
      check("queue_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
